// File: rtl/boot_load_sequencer.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, then releases the core.
// Mem write one cycle after a word's 4th byte; no backpressure, one byte per cycle is always accepted.
module boot_load_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic              RCU_Clk,
    input  logic              RCU_Reset,
    input  logic              BLS_Start,
    input  logic              BLS_Bypass,
    input  logic [7:0]        BLS_Rx_Data,
    input  logic              BLS_Rx_Valid,
    output logic              BLS_Mem_Wr,
    output logic [ADDR_W-1:0] BLS_Mem_Addr,
    output logic [31:0]       BLS_Mem_Data,
    output logic              BLS_Core_Run,
    output logic              BLS_Busy,
    output logic              BLS_Err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_RUN, S_ERROR
    } state_t;

    localparam int                CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [16:0]       CAP     = 17'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q;
    logic [ADDR_W-1:0]   last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          idx_q;
    logic [23:0]         word_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_data_q;

    logic [15:0] n_full;
    logic        timeout;
    logic        take_len0, take_len1, take_data;

    assign n_full    = {BLS_Rx_Data, len_lo_q};
    // The expiring edge is the one that would bring the idle count up to TIMEOUT.
    assign timeout   = (cnt_q == TO_LAST) && !BLS_Rx_Valid;
    assign take_len0 = (state_q == S_LEN0) && BLS_Rx_Valid;
    assign take_len1 = (state_q == S_LEN1) && BLS_Rx_Valid;
    assign take_data = (state_q == S_DATA) && BLS_Rx_Valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (BLS_Bypass)     state_d = S_RUN;
                else if (BLS_Start) state_d = S_LEN0;
            end
            S_LEN0: if (BLS_Rx_Valid) state_d = S_LEN1;
            S_LEN1: begin
                if (BLS_Rx_Valid) begin
                    if (n_full == 16'd0)          state_d = S_RUN;
                    else if ({1'b0, n_full} > CAP) state_d = S_ERROR;
                    else                           state_d = S_DATA;
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_DATA: begin
                // Leave only once the final word's strobe is on the bus.
                if (mem_wr_q && (mem_addr_q == last_q)) state_d = S_DONE;
                else if (timeout)                       state_d = S_ERROR;
            end
            S_DONE:  state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge RCU_Clk or negedge RCU_Reset) begin
        if (!RCU_Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge RCU_Clk or negedge RCU_Reset) begin
        if (!RCU_Reset) begin
            len_lo_q   <= '0;
            last_q     <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            word_q     <= '0;
            cnt_q      <= '0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            mem_wr_q <= 1'b0;
            if (take_len0) len_lo_q <= BLS_Rx_Data;
            if (take_len1) begin
                last_q <= ADDR_W'(n_full - 16'd1);
                addr_q <= '0;
                idx_q  <= '0;
            end
            if (take_data) begin
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    mem_wr_q   <= 1'b1;
                    mem_addr_q <= addr_q;
                    mem_data_q <= {BLS_Rx_Data, word_q};
                    addr_q     <= addr_q + ADDR_W'(1);
                end else begin
                    word_q <= {BLS_Rx_Data, word_q[23:8]};
                end
            end
            if ((state_q == S_LEN1) || (state_q == S_DATA)) begin
                if (BLS_Rx_Valid) cnt_q <= '0;
                else              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign BLS_Mem_Wr   = mem_wr_q;
    assign BLS_Mem_Addr = mem_addr_q;
    assign BLS_Mem_Data = mem_data_q;
    assign BLS_Core_Run = (state_q == S_RUN);
    assign BLS_Busy     = (state_q == S_LEN0) || (state_q == S_LEN1) || (state_q == S_DATA);
    assign BLS_Err      = (state_q == S_ERROR);

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Scoreboard bench for boot_load_sequencer: expected writes queued at stimulus time, popped by a monitor.
module tb_boot_load_sequencer;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;

    logic              RCU_Clk = 1'b0;
    logic              RCU_Reset = 1'b0;
    logic              BLS_Start = 1'b0;
    logic              BLS_Bypass = 1'b0;
    logic [7:0]        BLS_Rx_Data = 8'h00;
    logic              BLS_Rx_Valid = 1'b0;
    logic              BLS_Mem_Wr;
    logic [ADDR_W-1:0] BLS_Mem_Addr;
    logic [31:0]       BLS_Mem_Data;
    logic              BLS_Core_Run;
    logic              BLS_Busy;
    logic              BLS_Err;

    boot_load_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .RCU_Clk      (RCU_Clk),
        .RCU_Reset    (RCU_Reset),
        .BLS_Start    (BLS_Start),
        .BLS_Bypass   (BLS_Bypass),
        .BLS_Rx_Data  (BLS_Rx_Data),
        .BLS_Rx_Valid (BLS_Rx_Valid),
        .BLS_Mem_Wr   (BLS_Mem_Wr),
        .BLS_Mem_Addr (BLS_Mem_Addr),
        .BLS_Mem_Data (BLS_Mem_Data),
        .BLS_Core_Run (BLS_Core_Run),
        .BLS_Busy     (BLS_Busy),
        .BLS_Err      (BLS_Err)
    );

    always #5 RCU_Clk = ~RCU_Clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc;
    int          run_at;
    logic [39:0] exp_q[$];
    int          wr_cyc[$];
    logic        prev_wr = 1'b0;
    logic [39:0] e;
    logic [7:0]  d[$];

    always @(posedge RCU_Clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge RCU_Clk) begin
        if (BLS_Mem_Wr) begin
            wr_cyc.push_back(cyc);
            chk("wr_single_cycle", prev_wr, 1'b0);
            chk("write_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", BLS_Mem_Addr, e[39:32]);
                chk("wr_data", BLS_Mem_Data, e[31:0]);
            end
        end
        prev_wr = BLS_Mem_Wr;
    end

    // Reference model: word i is bytes 4i..4i+3, first byte least significant, written to address i.
    task automatic expect_words(input logic [7:0] dq[$]);
        for (int i = 0; i < dq.size() / 4; i++)
            exp_q.push_back({8'(i), dq[4*i+3], dq[4*i+2], dq[4*i+1], dq[4*i]});
    endtask

    task automatic send_bytes(input logic [7:0] bq[$], input int gmin, input int gmax);
        foreach (bq[i]) begin
            BLS_Rx_Valid = 1'b0;
            repeat ($urandom_range(gmax, gmin)) @(negedge RCU_Clk);
            BLS_Rx_Data  = bq[i];
            BLS_Rx_Valid = 1'b1;
            @(negedge RCU_Clk);
        end
        BLS_Rx_Valid = 1'b0;
        last_acc = cyc;
    endtask

    task automatic pulse_start();
        BLS_Start = 1'b1;
        @(negedge RCU_Clk);
        BLS_Start = 1'b0;
    endtask

    task automatic wait_done();
        run_at = -1;
        for (int i = 0; i < 200; i++) begin
            if (BLS_Core_Run || BLS_Err) begin
                run_at = cyc;
                break;
            end
            @(negedge RCU_Clk);
        end
        chk("wait_bounded", run_at >= 0, 1'b1);
    endtask

    task automatic run_load(input logic [7:0] dq[$], input int gmin, input int gmax);
        logic [15:0] n;
        logic [7:0]  bq[$];
        n = 16'(dq.size() / 4);
        bq = {n[7:0], n[15:8]};
        foreach (dq[i]) bq.push_back(dq[i]);
        expect_words(dq);
        pulse_start();
        send_bytes(bq, gmin, gmax);
        wait_done();
        chk("run_after_load", BLS_Core_Run, 1'b1);
        chk("no_err_after_load", BLS_Err, 1'b0);
        chk("all_words_written", exp_q.size(), 0);
        chk("run_latency", run_at - last_acc, (n == 16'd0) ? 0 : 2);
        if (n != 16'd0) chk("last_strobe_latency", wr_cyc[$] - last_acc, 0);
    endtask

    task automatic do_reset();
        RCU_Reset = 1'b0;
        repeat (2) @(negedge RCU_Clk);
        RCU_Reset = 1'b1;
        @(negedge RCU_Clk);
        wr_cyc.delete();
    endtask

    task automatic rand_data(input int n);
        d.delete();
        repeat (4 * n) d.push_back(8'($urandom));
    endtask

    initial begin
        repeat (2) @(negedge RCU_Clk);
        chk("rst_mem_wr", BLS_Mem_Wr, 1'b0);
        chk("rst_mem_addr", BLS_Mem_Addr, '0);
        chk("rst_mem_data", BLS_Mem_Data, 32'h0);
        chk("rst_core_run", BLS_Core_Run, 1'b0);
        chk("rst_busy", BLS_Busy, 1'b0);
        chk("rst_err", BLS_Err, 1'b0);
        RCU_Reset = 1'b1;
        @(negedge RCU_Clk);

        // Bypass and Start together: Bypass wins; later traffic is ignored.
        chk("idle_core_held", BLS_Core_Run, 1'b0);
        BLS_Bypass = 1'b1;
        BLS_Start  = 1'b1;
        @(negedge RCU_Clk);
        BLS_Bypass = 1'b0;
        BLS_Start  = 1'b0;
        chk("bypass_run", BLS_Core_Run, 1'b1);
        chk("bypass_not_busy", BLS_Busy, 1'b0);
        pulse_start();
        send_bytes({8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44}, 0, 0);
        repeat (3) @(negedge RCU_Clk);
        chk("bypass_run_held", BLS_Core_Run, 1'b1);
        chk("bypass_no_writes", wr_cyc.size(), 0);
        do_reset();

        d = {8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        run_load(d, 0, 0);
        chk("two_word_strobes", wr_cyc.size(), 2);
        do_reset();

        rand_data(3);
        run_load(d, 0, 0);
        chk("b2b_strobes", wr_cyc.size(), 3);
        chk("b2b_spacing_0", wr_cyc[1] - wr_cyc[0], 4);
        chk("b2b_spacing_1", wr_cyc[2] - wr_cyc[1], 4);
        do_reset();

        for (int k = 0; k < 6; k++) begin
            rand_data($urandom_range(12, 1));
            run_load(d, 0, 3);
            do_reset();
        end

        rand_data(1 << ADDR_W);
        run_load(d, 0, 0);
        chk("capacity_strobes", wr_cyc.size(), 1 << ADDR_W);
        do_reset();

        d.delete();
        run_load(d, 0, 2);
        chk("zero_len_no_writes", wr_cyc.size(), 0);
        do_reset();

        pulse_start();
        send_bytes({8'h01, 8'h01}, 0, 0);
        chk("oversize_err", BLS_Err, 1'b1);
        chk("oversize_no_run", BLS_Core_Run, 1'b0);
        send_bytes({8'h01, 8'h02, 8'h03, 8'h04}, 0, 0);
        repeat (3) @(negedge RCU_Clk);
        chk("oversize_err_held", BLS_Err, 1'b1);
        chk("oversize_no_writes", wr_cyc.size(), 0);
        do_reset();

        // Timeout: 5 data bytes then silence; error lands exactly TIMEOUT edges after the last byte.
        rand_data(2);
        d = d[0:4];
        expect_words(d);
        pulse_start();
        send_bytes({8'h02, 8'h00, d[0], d[1], d[2], d[3], d[4]}, 0, 0);
        repeat (TIMEOUT - 1) @(negedge RCU_Clk);
        chk("timeout_not_early", BLS_Err, 1'b0);
        chk("timeout_busy", BLS_Busy, 1'b1);
        @(negedge RCU_Clk);
        chk("timeout_err", BLS_Err, 1'b1);
        chk("timeout_no_run", BLS_Core_Run, 1'b0);
        chk("timeout_partial_written", exp_q.size(), 0);
        do_reset();

        // Every byte arrives on the last permitted edge, so the load must complete.
        rand_data(2);
        run_load(d, TIMEOUT - 1, TIMEOUT - 1);
        do_reset();

        // Asynchronous reset while the 3rd byte of word 1 is on the bus.
        d = {8'h13, 8'h05, 8'h10, 8'h00, 8'hAA, 8'hBB};
        expect_words(d);
        pulse_start();
        send_bytes({8'h02, 8'h00, d[0], d[1], d[2], d[3], d[4], d[5]}, 0, 0);
        chk("midload_word0_written", exp_q.size(), 0);
        BLS_Rx_Data  = 8'hCC;
        BLS_Rx_Valid = 1'b1;
        #2 RCU_Reset = 1'b0;
        #1;
        chk("arst_mem_wr", BLS_Mem_Wr, 1'b0);
        chk("arst_mem_addr", BLS_Mem_Addr, '0);
        chk("arst_mem_data", BLS_Mem_Data, 32'h0);
        chk("arst_core_run", BLS_Core_Run, 1'b0);
        chk("arst_busy", BLS_Busy, 1'b0);
        chk("arst_err", BLS_Err, 1'b0);
        BLS_Rx_Valid = 1'b0;
        @(negedge RCU_Clk);
        RCU_Reset = 1'b1;
        @(negedge RCU_Clk);
        wr_cyc.delete();
        d = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(d, 0, 1);
        chk("fresh_load_strobes", wr_cyc.size(), 1);

        repeat (5) @(negedge RCU_Clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
